// File: rtl/scmp_bus_seq.sv
// SC/MP external bus cycle sequencer: BREQ/ENIN arbitration, ADS/RD/WR strobes, HOLD wait states.
// Optional hold_n-low watchdog enabled by defining SCMP_BUS_TIMEOUT_EN.
module scmp_bus_seq #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cyc_req,
    input  logic cyc_wr,
    output logic stall,
    output logic ads_n,
    output logic rd_n,
    output logic wr_n,
    output logic addr_oe,
    output logic data_oe,
    output logic breq_o,
    input  logic enin,
    output logic enout,
    input  logic hold_n,
    output logic bus_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_ADDR   = 3'd2,
        S_STROBE = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e state_q, state_d;
    logic   wr_q, wr_d;
    logic   ads_n_q, ads_n_d;
    logic   rd_n_q, rd_n_d;
    logic   wr_n_q, wr_n_d;
    logic   addr_oe_q, addr_oe_d;
    logic   data_oe_q, data_oe_d;
    logic   breq_q, breq_d;
    logic   in_strobe;

`ifdef SCMP_BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = 8;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             bus_err_q, bus_err_d;
`endif

    // Next state; output flops are loaded from the next state so strobes line up with it
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
`ifdef SCMP_BUS_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        bus_err_d = bus_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cyc_req) begin
                    state_d = S_REQ;
                    wr_d    = cyc_wr;
`ifdef SCMP_BUS_TIMEOUT_EN
                    bus_err_d = 1'b0;
`endif
                end
            end
            S_REQ: begin
                if (enin) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                state_d = S_STROBE;
`ifdef SCMP_BUS_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            S_STROBE: begin
                if (hold_n) begin
                    state_d = S_DONE;
                end else begin
`ifdef SCMP_BUS_TIMEOUT_EN
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                    if (tmo_cnt_d == TIMEOUT_CYCLES) begin
                        state_d   = S_DONE;
                        bus_err_d = 1'b1;
                    end
`endif
                end
            end
            S_DONE: begin
                // Parking keeps the bus: go straight back to ADDR without re-arbitrating
                if (cyc_req) begin
                    state_d = S_ADDR;
                    wr_d    = cyc_wr;
`ifdef SCMP_BUS_TIMEOUT_EN
                    bus_err_d = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_strobe = (state_d == S_STROBE);
        ads_n_d   = (state_d != S_ADDR);
        rd_n_d    = ~(in_strobe & ~wr_d);
        wr_n_d    = ~(in_strobe & wr_d);
        addr_oe_d = (state_d == S_ADDR) | in_strobe;
        data_oe_d = in_strobe & wr_d;
        breq_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wr_q      <= 1'b0;
            ads_n_q   <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            addr_oe_q <= 1'b0;
            data_oe_q <= 1'b0;
            breq_q    <= 1'b0;
`ifdef SCMP_BUS_TIMEOUT_EN
            tmo_cnt_q <= '0;
            bus_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            ads_n_q   <= ads_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            addr_oe_q <= addr_oe_d;
            data_oe_q <= data_oe_d;
            breq_q    <= breq_d;
`ifdef SCMP_BUS_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            bus_err_q <= bus_err_d;
`endif
        end
    end

    assign ads_n   = ads_n_q;
    assign rd_n    = rd_n_q;
    assign wr_n    = wr_n_q;
    assign addr_oe = addr_oe_q;
    assign data_oe = data_oe_q;
    assign breq_o  = breq_q;

    // Microcode PC is released in DONE so the next micro-op overlaps the bus turnaround
    assign stall = cyc_req & (state_q != S_DONE);
    assign enout = enin & ~breq_q;

`ifdef SCMP_BUS_TIMEOUT_EN
    assign bus_err = bus_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign bus_err        = 1'b0;
`endif

endmodule

// File: tb/tb_scmp_bus_seq.sv
// Randomized bench for scmp_bus_seq: transaction plans are expanded into per-cycle expected bus phases.
module tb_scmp_bus_seq;

    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_ADDR = 2;
    localparam int PH_STB  = 3;
    localparam int PH_DONE = 4;

    typedef struct {
        bit req;
        bit wr;
        bit en;
        bit hold;
        int ph;
        bit twr;
    } cyc_t;

    logic clk, rst_n, cyc_req, cyc_wr, enin, hold_n;
    logic stall, ads_n, rd_n, wr_n, addr_oe, data_oe, breq_o, enout, bus_err;

    int n_checks = 0;
    int n_fail   = 0;
    cyc_t plan[$];

    scmp_bus_seq #(.TIMEOUT_CYCLES(8'd4)) dut (
        .clk(clk), .rst_n(rst_n), .cyc_req(cyc_req), .cyc_wr(cyc_wr),
        .stall(stall), .ads_n(ads_n), .rd_n(rd_n), .wr_n(wr_n),
        .addr_oe(addr_oe), .data_oe(data_oe), .breq_o(breq_o),
        .enin(enin), .enout(enout), .hold_n(hold_n), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit req, input bit wr, input bit en, input bit hold);
        cyc_req = req;
        cyc_wr  = wr;
        enin    = en;
        hold_n  = hold;
    endtask

    function automatic logic [8:0] outs();
        return {stall, ads_n, rd_n, wr_n, addr_oe, data_oe, breq_o, enout, bus_err};
    endfunction

    // Expected pins from the bus phase the cycle is in
    function automatic logic [8:0] exp_out(cyc_t c);
        logic e_ads, e_rd, e_wr, e_aoe, e_doe, e_breq;
        e_ads = 1'b1; e_rd = 1'b1; e_wr = 1'b1; e_aoe = 1'b0; e_doe = 1'b0;
        e_breq = (c.ph != PH_IDLE);
        if (c.ph == PH_ADDR) begin
            e_ads = 1'b0; e_aoe = 1'b1;
        end else if (c.ph == PH_STB) begin
            e_aoe = 1'b1; e_doe = c.twr; e_rd = c.twr; e_wr = !c.twr;
        end
        return {c.req && (c.ph != PH_DONE), e_ads, e_rd, e_wr, e_aoe, e_doe, e_breq,
                c.en && !e_breq, 1'b0};
    endfunction

    task automatic push(input bit req, input bit wr, input bit en, input bit hold,
                        input int ph, input bit twr);
        cyc_t c;
        c.req = req; c.wr = wr; c.en = en; c.hold = hold; c.ph = ph; c.twr = twr;
        plan.push_back(c);
    endtask

    task automatic gen_plan(input int ntx);
        bit parked, cur_w, nxt_w, drop, park_next;
        int ew, hw, gap;
        parked = 1'b0;
        cur_w  = 1'b0;
        for (int t = 0; t < ntx; t++) begin
            if (!parked) cur_w = 1'($urandom_range(0, 1));
            ew = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0;
            hw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            drop = ($urandom_range(0, 4) == 0);
            park_next = (t < ntx - 1) && ($urandom_range(0, 2) == 0);
            if (t == 0) begin cur_w = 1'b0; ew = 0; hw = 0; drop = 0; park_next = 0; end
            if (t == 1) begin cur_w = 1'b1; ew = 0; hw = 3; drop = 0; park_next = 0; end
            if (t == 2) begin ew = 10; park_next = 1; end
            if (!parked) begin
                gap = int'($urandom_range(0, 2));
                for (int i = 0; i < gap; i++)
                    push(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), PH_IDLE, cur_w);
                push(1'b1, cur_w, 1'($urandom), 1'($urandom), PH_IDLE, cur_w);
                for (int i = 0; i < ew; i++)
                    push(1'b1, 1'($urandom), 1'b0, 1'($urandom), PH_REQ, cur_w);
                push(1'b1, 1'($urandom), 1'b1, 1'($urandom), PH_REQ, cur_w);
            end
            push(!drop, 1'($urandom), 1'($urandom), 1'($urandom), PH_ADDR, cur_w);
            for (int i = 0; i < hw; i++)
                push(!drop, 1'($urandom), 1'($urandom), 1'b0, PH_STB, cur_w);
            push(!drop, 1'($urandom), 1'($urandom), 1'b1, PH_STB, cur_w);
            nxt_w = 1'($urandom_range(0, 1));
            push(park_next, nxt_w, 1'($urandom), 1'($urandom), PH_DONE, cur_w);
            if (park_next) cur_w = nxt_w;
            parked = park_next;
        end
        push(1'b0, 1'b0, 1'b1, 1'b1, PH_IDLE, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b1, PH_IDLE, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs", 32'(outs()), 32'({1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
        rst_n = 1'b1;

        gen_plan(40);
        foreach (plan[k]) begin
            @(posedge clk);
            #1;
            drive(plan[k].req, plan[k].wr, plan[k].en, plan[k].hold);
            #2;
            check_eq($sformatf("c%0d_ph%0d", k, plan[k].ph), 32'(outs()), 32'(exp_out(plan[k])));
        end

        // Reset during a read STROBE, then first request right after release
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("pre_rst_rd_n", 32'(rd_n), 32'(0));
        rst_n = 1'b0;
        #1;
        check_eq("rst_async", 32'({rd_n, breq_o, addr_oe, ads_n, wr_n, data_oe}), 32'(6'b100110));
        @(posedge clk); #2;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_accept", 32'({breq_o, stall, ads_n}), 32'(3'b111));
        @(posedge clk); #1;
        check_eq("post_rst_addr", 32'({ads_n, addr_oe}), 32'(2'b01));
        @(posedge clk); #1;
        check_eq("post_rst_wr", 32'({wr_n, rd_n, data_oe}), 32'(3'b011));
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        check_eq("post_rst_done", 32'({wr_n, data_oe, breq_o, stall}), 32'(4'b1010));
        @(posedge clk); #1;
        check_eq("post_rst_idle", 32'({breq_o, enout}), 32'(2'b01));

`ifdef SCMP_BUS_TIMEOUT_EN
        // hold_n stuck low: four STROBE cycles, forced DONE, sticky error
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("tmo_stb%0d", i), 32'({wr_n, bus_err}), 32'(2'b00));
            @(posedge clk);
        end
        #1;
        check_eq("tmo_done", 32'({wr_n, data_oe, breq_o, bus_err}), 32'(4'b1011));
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        check_eq("tmo_sticky", 32'({breq_o, bus_err}), 32'(2'b01));
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        check_eq("tmo_clear", 32'({breq_o, bus_err}), 32'(2'b10));
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
